// File: rtl/cva5_fifo_reader.sv
// cva5_fifo_reader: drains a small FIFO into a registered valid/ready stream.
// A two-entry (head + skid) buffer lets the FIFO pop decision depend only on
// registered occupancy, so out_ready never reaches fifo_pop combinationally.
module cva5_fifo_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_valid,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   fifo_pop,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] out_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] skid;
    logic                  accept;

    assign accept   = out_valid & out_ready;
    assign out_data = head;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= next_state;
    end

    // Occupancy transitions; flush overrides everything
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (fifo_pop) next_state = ONE;
                ONE: begin
                    if (fifo_pop && !accept)      next_state = TWO;
                    else if (!fifo_pop && accept) next_state = EMPTY;
                end
                TWO:   if (accept) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    // Outputs: pop only from registered state, never from out_ready
    always_comb begin
        out_valid = (state != EMPTY);
        fifo_pop  = fifo_valid & ~flush & (state != TWO) & rst;
    end

    // Head/skid data moves; contents after a flush are don't-care
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            skid <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: if (fifo_pop) head <= fifo_data;
                ONE: begin
                    if (fifo_pop && accept)       head <= fifo_data;
                    else if (fifo_pop && !accept) skid <= fifo_data;
                end
                TWO:   if (accept) head <= skid;
                default: ;
            endcase
        end
    end

    // Delivered-entry counter; an accept in a flush cycle still counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        out_count <= '0;
        else if (accept) out_count <= out_count + COUNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_cva5_fifo_reader.sv
// Bench for cva5_fifo_reader: queue-based reference of in-flight entries,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_cva5_fifo_reader;
    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_valid = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_pop;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_count;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] src[$];   // environment FIFO contents
    logic          fv_en = 1'b0;
    logic          pop_s = 1'b0;
    logic [DW-1:0] mq[$];    // entries popped but not yet delivered
    int            mcnt = 0;
    logic          acc_m, pop_m, exp_pop;
    int            seq = 0;

    cva5_fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd_src();
        fifo_valid = fv_en && (src.size() > 0);
        fifo_data  = (src.size() > 0) ? src[0] : '0;
    endtask

    // advance to just after the next rising edge and retire a popped entry
    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_s && src.size() > 0) void'(src.pop_front());
        upd_src();
    endtask

    // Reference: a queue of at most two entries; pop when room, deliver head
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            acc_m = (mq.size() > 0) && out_ready;
            pop_m = fifo_valid && !flush && (mq.size() < 2);
            if (acc_m) begin
                void'(mq.pop_front());
                mcnt = (mcnt + 1) % (1 << CW);
            end
            if (flush)      mq.delete();
            else if (pop_m) mq.push_back(fifo_data);
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        pop_s   = fifo_pop;
        exp_pop = rst && fifo_valid && !flush && (mq.size() < 2);
        chk("pop", 32'(fifo_pop), 32'(exp_pop));
        chk("valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) chk("data", 32'(out_data), 32'(mq[0]));
        if (!rst) chk("rst_data", 32'(out_data), 32'h0);
        chk("count", 32'(out_count), 32'(mcnt));
    end

    initial begin
        #1 rst = 1'b0;
        // reset state, FIFO already offering entries
        src.push_back(16'h11); src.push_back(16'h22); src.push_back(16'h33);
        fv_en = 1'b1;
        upd_src();
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pop", 32'(fifo_pop), 0);
        chk("rst_cnt", 32'(out_count), 0);
        chk("rst_out", 32'(out_data), 0);
        tick();

        // back-to-back streaming
        rst = 1'b1; out_ready = 1'b1; upd_src();
        @(negedge clk); chk("s_pop1", 32'(fifo_pop), 1); chk("s_v1", 32'(out_valid), 0); tick();
        @(negedge clk); chk("s_d11", 32'(out_data), 32'h11); chk("s_pop2", 32'(fifo_pop), 1); tick();
        @(negedge clk); chk("s_d22", 32'(out_data), 32'h22); chk("s_pop3", 32'(fifo_pop), 1); tick();
        @(negedge clk); chk("s_d33", 32'(out_data), 32'h33); chk("s_pop4", 32'(fifo_pop), 0); tick();
        @(negedge clk); chk("s_cnt", 32'(out_count), 3); chk("s_v5", 32'(out_valid), 0); tick();

        // stall: two pops, then hold
        out_ready = 1'b0;
        src.push_back(16'hA); src.push_back(16'hB); src.push_back(16'hC); upd_src();
        @(negedge clk); chk("b_pop1", 32'(fifo_pop), 1); tick();
        @(negedge clk); chk("b_pop2", 32'(fifo_pop), 1); chk("b_dA", 32'(out_data), 32'hA); tick();
        repeat (3) begin
            @(negedge clk); chk("b_hold_pop", 32'(fifo_pop), 0); chk("b_hold_d", 32'(out_data), 32'hA); tick();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("b_oA", 32'(out_data), 32'hA); tick();
        @(negedge clk); chk("b_oB", 32'(out_data), 32'hB); tick();
        @(negedge clk); chk("b_oC", 32'(out_data), 32'hC); tick();
        @(negedge clk); chk("b_cnt", 32'(out_count), 6); chk("b_v", 32'(out_valid), 0); tick();

        // flush while full, downstream stalled
        out_ready = 1'b0;
        src.push_back(16'h21); src.push_back(16'h22); src.push_back(16'hD); upd_src();
        tick(); tick();
        flush = 1'b1;
        @(negedge clk); chk("f_pop", 32'(fifo_pop), 0); tick();
        flush = 1'b0;
        @(negedge clk); chk("f_v", 32'(out_valid), 0); chk("f_cnt", 32'(out_count), 6); chk("f_pop2", 32'(fifo_pop), 1); tick();
        @(negedge clk); chk("f_dD", 32'(out_data), 32'hD); chk("f_v2", 32'(out_valid), 1); tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk); chk("f_cnt2", 32'(out_count), 7); tick();

        // flush coinciding with an accept
        out_ready = 1'b0;
        src.push_back(16'h55); upd_src();
        tick();
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk); chk("fa_d55", 32'(out_data), 32'h55); tick();
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk); chk("fa_v", 32'(out_valid), 0); chk("fa_cnt", 32'(out_count), 8); tick();

        // reset while full
        src.push_back(16'h61); src.push_back(16'h62); src.push_back(16'h63); upd_src();
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("r_v", 32'(out_valid), 0); chk("r_pop", 32'(fifo_pop), 0); chk("r_cnt", 32'(out_count), 0);
        tick();
        rst = 1'b1; out_ready = 1'b1;
        @(negedge clk); chk("r_pop2", 32'(fifo_pop), 1); tick();
        @(negedge clk); chk("r_d63", 32'(out_data), 32'h63); tick();

        // counter wrap: 17 accepts from zero
        rst = 1'b0; tick(); rst = 1'b1;
        for (int i = 0; i < 17; i++) src.push_back(DW'(16'h100 + i));
        upd_src();
        repeat (22) tick();
        @(negedge clk); chk("w_cnt", 32'(out_count), 1); chk("w_v", 32'(out_valid), 0); tick();

        // randomized traffic with occasional flush
        for (int c = 0; c < 10000; c++) begin
            while (src.size() < 4) begin
                src.push_back(DW'(seq));
                seq++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            fv_en     = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            upd_src();
            tick();
        end
        flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
